// File: rtl/rpn_sequencer.sv
// Command sequencer for the RPN calculator: accepts one decoded command at a time,
// checks stack depth, and issues ordered pop/push strobes with ALU operands taken from capture registers.
module rpn_sequencer #(
  parameter int DATA_W = 16,
  parameter int PTR_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_val,
  input  logic [DATA_W-1:0] stack_top,
  input  logic [DATA_W-1:0] stack_next,
  input  logic [PTR_W-1:0]  stack_ptr,
  input  logic              stack_full,
  output logic              pop,
  output logic              push,
  output logic [31:0]       data_in,
  output logic [3:0]        alu_op,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  output logic [7:0]        shamt,
  input  logic [31:0]       alu_lo,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [7:0]        counter
);

  localparam logic [3:0] OP_PUSH  = 4'd0;
  localparam logic [3:0] OP_POP   = 4'd1;
  localparam logic [3:0] OP_SWAP  = 4'd12;

  localparam logic [1:0] E_NONE  = 2'd0;
  localparam logic [1:0] E_UNDER = 2'd1;
  localparam logic [1:0] E_OVER  = 2'd2;
  localparam logic [1:0] E_ILL   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP1,
    S_POP2,
    S_PUSH1,
    S_PUSH2,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state;
  logic [3:0]        op_cap;
  logic [DATA_W-1:0] val_cap;
  logic [DATA_W-1:0] top_cap;
  logic [DATA_W-1:0] next_cap;
  logic [1:0]        chk_code;
  logic              unused_alu_hi;

  function automatic logic [3:0] alu_op_of(input logic [3:0] op);
    case (op)
      4'd2:    alu_op_of = 4'b0100;
      4'd3:    alu_op_of = 4'b0101;
      4'd4:    alu_op_of = 4'b1000;
      4'd5:    alu_op_of = 4'b1001;
      4'd6:    alu_op_of = 4'b1101;
      4'd7:    alu_op_of = 4'b0000;
      4'd8:    alu_op_of = 4'b0001;
      4'd9:    alu_op_of = 4'b0011;
      4'd10:   alu_op_of = 4'b0010;
      4'd11:   alu_op_of = 4'b0110;
      default: alu_op_of = 4'b0000;
    endcase
  endfunction

  // Priority: illegal opcode, then overflow on PUSH, then underflow for pops.
  function automatic logic [1:0] check_of(input logic [3:0] op,
                                          input logic [PTR_W-1:0] ptr,
                                          input logic full);
    if (op > OP_SWAP)
      check_of = E_ILL;
    else if (op == OP_PUSH)
      check_of = full ? E_OVER : E_NONE;
    else if (op == OP_POP)
      check_of = (ptr < PTR_W'(1)) ? E_UNDER : E_NONE;
    else
      check_of = (ptr < PTR_W'(2)) ? E_UNDER : E_NONE;
  endfunction

  assign chk_code      = check_of(cmd_op, stack_ptr, stack_full);
  assign alu_a         = 32'(next_cap);
  assign alu_b         = 32'(top_cap);
  assign shamt         = {3'b000, top_cap[4:0]};
  assign unused_alu_hi = ^{alu_lo[31:DATA_W], val_cap};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b1;
      pop       <= 1'b0;
      push      <= 1'b0;
      data_in   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= E_NONE;
      counter   <= '0;
      op_cap    <= '0;
      val_cap   <= '0;
      top_cap   <= '0;
      next_cap  <= '0;
      alu_op    <= '0;
    end else begin
      pop      <= 1'b0;
      push     <= 1'b0;
      data_in  <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= E_NONE;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_cap    <= cmd_op;
            val_cap   <= cmd_val;
            top_cap   <= stack_top;
            next_cap  <= stack_next;
            alu_op    <= alu_op_of(cmd_op);
            cmd_ready <= 1'b0;
            if (chk_code != E_NONE) begin
              state    <= S_ERR;
              done     <= 1'b1;
              err      <= 1'b1;
              err_code <= chk_code;
            end else if (cmd_op == OP_PUSH) begin
              state   <= S_PUSH1;
              push    <= 1'b1;
              data_in <= 32'(cmd_val);
            end else begin
              state <= S_POP1;
              pop   <= 1'b1;
            end
          end
        end
        S_POP1: begin
          if (op_cap == OP_POP) begin
            state   <= S_DONE;
            done    <= 1'b1;
            counter <= counter + 8'd1;
          end else begin
            state <= S_POP2;
            pop   <= 1'b1;
          end
        end
        // ALU result is already settled here since its operands come from capture regs.
        S_POP2: begin
          state <= S_PUSH1;
          push  <= 1'b1;
          if (op_cap == OP_SWAP)
            data_in <= 32'(top_cap);
          else
            data_in <= 32'(alu_lo[DATA_W-1:0]);
        end
        S_PUSH1: begin
          if (op_cap == OP_SWAP) begin
            state   <= S_PUSH2;
            push    <= 1'b1;
            data_in <= 32'(next_cap);
          end else begin
            state   <= S_DONE;
            done    <= 1'b1;
            counter <= counter + 8'd1;
          end
        end
        S_PUSH2: begin
          state   <= S_DONE;
          done    <= 1'b1;
          counter <= counter + 8'd1;
        end
        S_DONE, S_ERR: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
        end
        default: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rpn_sequencer.sv
// Directed bench for rpn_sequencer with a behavioural ALU driving alu_lo.
module tb_rpn_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [15:0] cmd_val;
  logic [15:0] stack_top;
  logic [15:0] stack_next;
  logic [5:0]  stack_ptr;
  logic        stack_full;
  logic        pop;
  logic        push;
  logic [31:0] data_in;
  logic [3:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [7:0]  shamt;
  logic [31:0] alu_lo;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [7:0]  counter;

  int checks = 0;
  int fails  = 0;

  rpn_sequencer #(.DATA_W(16), .PTR_W(6)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_val(cmd_val), .stack_top(stack_top), .stack_next(stack_next),
    .stack_ptr(stack_ptr), .stack_full(stack_full), .pop(pop), .push(push),
    .data_in(data_in), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .shamt(shamt),
    .alu_lo(alu_lo), .done(done), .err(err), .err_code(err_code), .counter(counter)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_lo = 32'd0;
    case (alu_op)
      4'b0100: alu_lo = alu_a + alu_b;
      4'b0101: alu_lo = alu_a - alu_b;
      4'b1000: alu_lo = alu_a << shamt[4:0];
      4'b1001: alu_lo = alu_a >> shamt[4:0];
      4'b1101: alu_lo = {31'd0, alu_a < alu_b};
      4'b0000: alu_lo = alu_a & alu_b;
      4'b0001: alu_lo = alu_a | alu_b;
      4'b0011: alu_lo = ~(alu_a | alu_b);
      4'b0010: alu_lo = alu_a ^ alu_b;
      4'b0110: alu_lo = alu_a * alu_b;
      default: alu_lo = 32'd0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one command, then watch strobes until done (bounded to 10 cycles).
  task automatic run_cmd(input string tag, input logic [3:0] op, input logic [15:0] val,
                         input logic [15:0] top, input logic [15:0] nxt,
                         input logic [5:0] ptr, input logic full,
                         input int exp_pops, input int exp_push,
                         input logic [31:0] exp_d0, input logic [31:0] exp_d1,
                         input int exp_lat, input logic exp_err, input logic [1:0] exp_code);
    int npop, npush, lat, both, stray;
    logic [31:0] d [2];
    logic got_err;
    logic [1:0] got_code;
    npop = 0; npush = 0; lat = 0; both = 0; stray = 0;
    d[0] = '0; d[1] = '0; got_err = 1'b0; got_code = 2'd0;
    @(negedge clk);
    check({tag, " ready"}, {31'd0, cmd_ready}, 32'd1);
    cmd_op = op; cmd_val = val; stack_top = top; stack_next = nxt;
    stack_ptr = ptr; stack_full = full; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    stack_top = 16'hDEAD; stack_next = 16'hBEEF; stack_ptr = 6'd0; stack_full = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (pop && push) both++;
      if (!push && data_in != 32'd0) stray++;
      if (pop) npop++;
      if (push) begin
        if (npush < 2) d[npush] = data_in;
        npush++;
      end
      if (done) begin
        lat = cyc; got_err = err; got_code = err_code;
        break;
      end
      if (err_code != 2'd0) stray++;
    end
    check({tag, " pops"}, npop, exp_pops);
    check({tag, " pushes"}, npush, exp_push);
    if (exp_push >= 1) check({tag, " data0"}, d[0], exp_d0);
    if (exp_push >= 2) check({tag, " data1"}, d[1], exp_d1);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " err"}, {31'd0, got_err}, {31'd0, exp_err});
    check({tag, " err_code"}, {30'd0, got_code}, {30'd0, exp_code});
    check({tag, " strobe_rules"}, both + stray, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rdy_hi, npop, dn_cyc;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_val = '0;
    stack_top = '0; stack_next = '0; stack_ptr = '0; stack_full = 1'b0;
    #12;
    check("rst cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst strobes", {30'd0, pop, push}, 32'd0);
    check("rst done", {30'd0, done, err}, 32'd0);
    check("rst counter", {24'd0, counter}, 32'd0);
    check("rst alu_op", {28'd0, alu_op}, 32'd0);
    @(negedge clk); rst = 1'b0;

    run_cmd("push7", 4'd0, 16'h0007, 16'h0, 16'h0, 6'd0, 1'b0, 0, 1, 32'h7, 32'h0, 2, 1'b0, 2'd0);
    run_cmd("push3", 4'd0, 16'h0003, 16'h7, 16'h0, 6'd1, 1'b0, 0, 1, 32'h3, 32'h0, 2, 1'b0, 2'd0);
    check("counter after pushes", {24'd0, counter}, 32'd2);
    run_cmd("add", 4'd2, 16'h0, 16'h0003, 16'h0007, 6'd2, 1'b0, 2, 1, 32'h000A, 32'h0, 4, 1'b0, 2'd0);
    check("add alu_op", {28'd0, alu_op}, 32'b0100);
    check("counter after add", {24'd0, counter}, 32'd3);
    run_cmd("sub_pos", 4'd3, 16'h0, 16'h0003, 16'h0007, 6'd2, 1'b0, 2, 1, 32'h0004, 32'h0, 4, 1'b0, 2'd0);
    run_cmd("sub_neg", 4'd3, 16'h0, 16'h0007, 16'h0003, 6'd2, 1'b0, 2, 1, 32'hFFFC, 32'h0, 4, 1'b0, 2'd0);
    run_cmd("sltu", 4'd6, 16'h0, 16'h0007, 16'h0003, 6'd2, 1'b0, 2, 1, 32'h0001, 32'h0, 4, 1'b0, 2'd0);
    check("sltu alu_op", {28'd0, alu_op}, 32'b1101);
    run_cmd("swap", 4'd12, 16'h0, 16'h1111, 16'h2222, 6'd2, 1'b0, 2, 2, 32'h1111, 32'h2222, 5, 1'b0, 2'd0);
    check("counter after swap", {24'd0, counter}, 32'd7);
    run_cmd("sll", 4'd4, 16'h0, 16'h0024, 16'h0003, 6'd3, 1'b0, 2, 1, 32'h0030, 32'h0, 4, 1'b0, 2'd0);
    check("sll shamt", {24'd0, shamt}, 32'h04);
    run_cmd("multu", 4'd11, 16'h0, 16'h0010, 16'h1234, 6'd3, 1'b0, 2, 1, 32'h2340, 32'h0, 4, 1'b0, 2'd0);
    check("multu alu_op", {28'd0, alu_op}, 32'b0110);
    run_cmd("nor", 4'd9, 16'h0, 16'h0F00, 16'h00FF, 6'd3, 1'b0, 2, 1, 32'hF000, 32'h0, 4, 1'b0, 2'd0);
    run_cmd("add_carry", 4'd2, 16'h0, 16'h0002, 16'hFFFF, 6'd2, 1'b0, 2, 1, 32'h0001, 32'h0, 4, 1'b0, 2'd0);
    check("counter after alu ops", {24'd0, counter}, 32'd11);

    run_cmd("err_under", 4'd2, 16'h0, 16'h0003, 16'h0007, 6'd1, 1'b0, 0, 0, 32'h0, 32'h0, 1, 1'b1, 2'd1);
    run_cmd("err_over", 4'd0, 16'h0055, 16'h0, 16'h0, 6'd63, 1'b1, 0, 0, 32'h0, 32'h0, 1, 1'b1, 2'd2);
    run_cmd("err_ill", 4'd14, 16'h0, 16'h0, 16'h0, 6'd5, 1'b1, 0, 0, 32'h0, 32'h0, 1, 1'b1, 2'd3);
    run_cmd("err_pop0", 4'd1, 16'h0, 16'h0, 16'h0, 6'd0, 1'b0, 0, 0, 32'h0, 32'h0, 1, 1'b1, 2'd1);
    check("counter after errors", {24'd0, counter}, 32'd11);
    run_cmd("pop", 4'd1, 16'h0, 16'h0009, 16'h0, 6'd1, 1'b0, 1, 0, 32'h0, 32'h0, 2, 1'b0, 2'd0);
    check("counter after pop", {24'd0, counter}, 32'd12);

    // cmd_valid stays high through a busy ADD: only one accept until DONE clears.
    @(negedge clk);
    cmd_op = 4'd2; stack_top = 16'h0001; stack_next = 16'h0002; stack_ptr = 6'd2;
    cmd_valid = 1'b1;
    rdy_hi = 0; npop = 0; dn_cyc = 0;
    @(posedge clk);
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      if (cmd_ready) rdy_hi++;
      if (pop) npop++;
      if (done) dn_cyc = cyc;
    end
    check("hold ready_busy", rdy_hi, 0);
    check("hold pops", npop, 2);
    check("hold done_cycle", dn_cyc, 4);
    @(negedge clk);
    check("hold ready_after", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b0;
    check("counter after hold", {24'd0, counter}, 32'd13);

    // Reset asserted during POP2 of an ADD.
    @(negedge clk);
    cmd_op = 4'd2; stack_top = 16'h0004; stack_next = 16'h0005; stack_ptr = 6'd2;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid pop2 active", {31'd0, pop}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst strobes", {30'd0, pop, push}, 32'd0);
    check("mid_rst ready", {31'd0, cmd_ready}, 32'd1);
    check("mid_rst counter", {24'd0, counter}, 32'd0);
    check("mid_rst done", {31'd0, done}, 32'd0);
    @(negedge clk); rst = 1'b0;
    dn_cyc = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      if (done || pop || push) dn_cyc++;
    end
    check("post_rst quiet", dn_cyc, 0);
    run_cmd("push_after_rst", 4'd0, 16'h0005, 16'h0, 16'h0, 6'd0, 1'b0, 0, 1, 32'h5, 32'h0, 2, 1'b0, 2'd0);
    check("counter after rst", {24'd0, counter}, 32'd1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/rpn_sequencer.md
Name: rpn_sequencer

Overview:
- Command-level controller for the RPN calculator datapath. It sits between the keypad/mode decode and the stack plus ALU.
- Accepts one decoded command at a time over a valid/ready handshake. It then captures operands, checks stack depth, and issues single-cycle pop/push strobes to the stack in a fixed order.
- It drives the ALU opcode and operands, and reports completion or error.
- Replaces ad-hoc per-case pop/push sequencing with one FSM shared by all 13 operations.

Parameters:
- DATA_W, 16, stack entry / switch value width.
- PTR_W, 6, stack pointer (depth) width.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  sequencer can accept (high only in IDLE)
- cmd_op  input  4  command opcode (encoding below)
- cmd_val  input  DATA_W  literal for PUSH
- stack_top  input  DATA_W  current top of stack
- stack_next  input  DATA_W  second-from-top
- stack_ptr  input  PTR_W  current depth
- stack_full  input  1  stack full
- pop  output  1  single-cycle pop strobe
- push  output  1  single-cycle push strobe
- data_in  output  32  push data, zero-extended DATA_W
- alu_op  output  4  ALU opcode
- alu_a  output  32  ALU a = captured next, zero-extended
- alu_b  output  32  ALU b = captured top, zero-extended
- shamt  output  8  {3'b0, captured top[4:0]}
- alu_lo  input  32  ALU low result
- done  output  1  one-cycle pulse at command completion
- err  output  1  valid with done; 1 = command rejected
- err_code  output  2  valid with done: 0 none, 1 underflow, 2 overflow, 3 illegal op
- counter  output  8  successful commands completed, wraps 255->0

Behaviour:
- Reset (async, rst=1): state IDLE. All outputs 0 except cmd_ready=1. Capture regs, alu_op and counter are 0.
- cmd_op encoding, with ALU op in brackets:
  - 0 PUSH, 1 POP
  - 2 ADD[0100], 3 SUB[0101], 4 SLL[1000], 5 SRL[1001], 6 SLTU[1101]
  - 7 AND[0000], 8 OR[0001], 9 NOR[0011], 10 XOR[0010], 11 MULTU[0110]
  - 12 SWAP
  - 13-15 illegal
- Accept: on a clk edge with cmd_valid && cmd_ready, register the following into capture regs, stable until the next accept:
  - cmd_op, cmd_val, stack_top (top_cap), stack_next (next_cap)
  - alu_op for the command
- The legality check at accept uses that cycle's stack_ptr/stack_full, in priority order:
  - illegal op -> code 3
  - PUSH with stack_full -> code 2
  - POP with stack_ptr<1 -> code 1
  - binary or SWAP with stack_ptr<2 -> code 1
  - On error: next state ERR. No pop/push is ever issued.
- States: IDLE, POP1, POP2, PUSH1, PUSH2, DONE, ERR. Outputs are decoded from state (Moore). Exactly one strobe per POP/PUSH state.
- Sequences (state after accept edge):
  - PUSH: PUSH1 (data_in=cmd_val) -> DONE.
  - POP: POP1 -> DONE.
  - Binary ops: POP1 -> POP2 -> PUSH1 (data_in=alu_lo[DATA_W-1:0]) -> DONE.
  - SWAP: POP1 -> POP2 -> PUSH1 (data_in=top_cap) -> PUSH2 (data_in=next_cap) -> DONE. Resulting top = old next, next = old top.
- ALU inputs are driven from the capture regs only, never from live stack outputs. The result is therefore unaffected by the pops.
- Operand order is RPN:
  - SUB = next-top.
  - SLL/SRL shift next by top[4:0].
  - SLTU pushes 1 if next<top unsigned, else 0.
- Results are truncated to DATA_W, including MULTU (low DATA_W bits) and ADD carry.
- DONE: done=1, err=0, counter+=1 (wraps) -> IDLE.
- ERR: done=1, err=1, err_code held from accept, counter unchanged -> IDLE.
- err_code is 0 whenever done=0.
- Latency from accept edge to done cycle:
  - PUSH/POP: 2 cycles
  - binary ops: 4 cycles
  - SWAP: 5 cycles
  - error: 1 cycle
- Throughput: cmd_ready=0 from accept until return to IDLE. cmd_valid held during busy states is ignored, not queued. The next command can be accepted in the cycle after DONE/ERR.
- data_in is 0 outside push states. pop and push are never both high.
- Reset mid-operation: immediate return to IDLE with strobes deasserted. Pops already issued are not undone. No done pulse is produced.

Test Plan:
- Reset, then PUSH 0x0007, then PUSH 0x0003 -> push pulses 2 cycles apart per command, done with err=0, counter=2.
- Stack top=3, next=7, ADD -> pop in two consecutive cycles, then push with data_in=0x000A, done 4 cycles after accept, counter increments.
- SUB with top=3, next=7 -> pushes 0x0004. SUB with top=7, next=3 -> pushes 0xFFFC. SLTU with next=3, top=7 -> pushes 0x0001.
- SWAP with top=0x1111, next=0x2222 -> 2 pops, then push 0x1111, then push 0x2222. Final top=0x2222, next=0x1111.
- ADD with stack_ptr=1 -> done+err, err_code=1, no strobes. PUSH with stack_full=1 -> err_code=2. cmd_op=14 -> err_code=3. Counter unchanged in all three cases.
- Assert rst during POP2 of an ADD -> all strobes 0 immediately, cmd_ready=1, counter=0, no done. Hold cmd_valid during a busy ADD -> no second accept until after DONE.
